// File: rtl/fsm_counter.sv
// fsm_counter: 3-bit Moore counter built as an eight-state machine (S0..S7).
// It advances one state on each rising clk edge that samples en=1, wraps from
// S7 to S0, and holds when en=0. reset_n is active-HIGH despite its name: it
// forces S0 immediately, with no clock edge needed, and overrides en while held.
module fsm_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic [2:0] num
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // State register; the asynchronous reset drives it straight to S0.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= S0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: step by one when enabled, otherwise hold. Any encoding
  // outside the eight states goes back to S0 whatever en is. With a dense
  // 3-bit encoding there is no spare code, so the default arm is defensive only.
  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0:      w_next_state = en ? S1 : S0;
      S1:      w_next_state = en ? S2 : S1;
      S2:      w_next_state = en ? S3 : S2;
      S3:      w_next_state = en ? S4 : S3;
      S4:      w_next_state = en ? S5 : S4;
      S5:      w_next_state = en ? S6 : S5;
      S6:      w_next_state = en ? S7 : S6;
      S7:      w_next_state = en ? S0 : S7;
      default: w_next_state = S0;
    endcase
  end

  // Moore output: num depends only on the current state. The state codes equal
  // the count values, so num is the state register itself.
  always_comb begin
    num = 3'd0;
    case (r_state)
      S0:      num = 3'd0;
      S1:      num = 3'd1;
      S2:      num = 3'd2;
      S3:      num = 3'd3;
      S4:      num = 3'd4;
      S5:      num = 3'd5;
      S6:      num = 3'd6;
      S7:      num = 3'd7;
      default: num = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_fsm_counter.sv
// tb_fsm_counter: directed and random stimulus for fsm_counter. Every result
// is checked against a count model in the bench that works modulo 8.
module tb_fsm_counter;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset_n = 1'b0;
  logic       en      = 1'b0;
  logic [2:0] num;

  int model    = 0;
  int n_checks = 0;
  int n_fail   = 0;

  fsm_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .num     (num)
  );

  // The clock toggles every 5 time units, but only while clk_run is set.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag);
    n_checks++;
    assert (num === 3'(model))
    else begin
      n_fail++;
      $error("FAIL %s: num=%0d expected %0d", tag, num, model);
    end
    $display("check %0d %s: en=%0b reset_n=%0b num=%0d expected=%0d",
             n_checks, tag, en, reset_n, num, model);
  endtask

  // Drive en (1 time unit after an edge), wait for the next rising edge,
  // update the model, then sample 1 time unit later.
  task automatic tick(input logic e, input string tag);
    en = e;
    @(posedge clk);
    if (reset_n) model = 0;
    else if (e)  model = (model + 1) % 8;
    #1;
    check(tag);
  endtask

  initial begin
    // Reset asserted while the clock is stopped.
    #1 reset_n = 1'b1;
    model = 0;
    #2 check("reset_no_clock");

    // Start the clock. While reset is held, en=1 must not move the count.
    clk_run = 1'b1;
    tick(1'b1, "reset_dominates_en");
    tick(1'b1, "reset_dominates_en");

    // Free run: release reset at a falling edge, then run 20 enabled cycles.
    @(negedge clk);
    reset_n = 1'b0;
    en      = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b1, "free_run");

    // Hold: count up to 5, hold for 4 edges, then step to 6.
    while (model != 5) tick(1'b1, "count_to_5");
    for (int i = 0; i < 4; i++) tick(1'b0, "hold_at_5");
    tick(1'b1, "after_hold_6");

    // Wrap: count up to 7, then 0, then 1.
    while (model != 7) tick(1'b1, "count_to_7");
    tick(1'b1, "wrap_to_0");
    tick(1'b1, "wrap_then_1");

    // Mid-operation reset: at 3, assert reset between edges.
    while (model != 3) tick(1'b1, "count_to_3");
    #2 reset_n = 1'b1;
    model = 0;
    #1 check("async_reset_mid");
    tick(1'b1, "reset_held_en1");
    tick(1'b1, "reset_held_en1");
    @(negedge clk);
    reset_n = 1'b0;
    tick(1'b0, "after_release_en0");
    tick(1'b1, "after_release_en1");

    // Random en, with occasional asynchronous reset pulses between edges.
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 15) == 0) begin
        #2 reset_n = 1'b1;
        model = 0;
        #1 check("random_async_reset");
        #1 reset_n = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
